mem_arbiter: RTL and testbench

- Shares one main-memory port between the data cache (read/write) and the instruction cache (read-only).
- Sits between both cache controllers and the memory model, below the cpu top level.
- Grants requests round-robin, sequences each memory transaction, and returns data and BUSYWAIT release to the winning requester.
- Watches memory latency with a timeout counter.

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter_rr_arbiter2.sv | 23 ++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and default widths for the two-cache memory arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF         = 6;
  localparam int DATA_W_DEF         = 32;
  localparam int TIMEOUT_CYCLES_DEF = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic OWN_D = 1'b0;
  localparam logic OWN_I = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side bus of the arbiter; slave is the arbiter's view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              D_READ;
  logic              D_WRITE;
  logic [ADDR_W-1:0] D_ADDRESS;
  logic [DATA_W-1:0] D_WRITEDATA;
  logic [DATA_W-1:0] D_READDATA;
  logic              D_BUSYWAIT;
  logic              I_READ;
  logic [ADDR_W-1:0] I_ADDRESS;
  logic [DATA_W-1:0] I_READDATA;
  logic              I_BUSYWAIT;
  logic              MEM_READ;
  logic              MEM_WRITE;
  logic [ADDR_W-1:0] MEM_ADDRESS;
  logic [DATA_W-1:0] MEM_WRITEDATA;
  logic [DATA_W-1:0] MEM_READDATA;
  logic              MEM_BUSYWAIT;

  modport slave (
    input  D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA, I_READ, I_ADDRESS,
    input  MEM_READDATA, MEM_BUSYWAIT,
    output D_READDATA, D_BUSYWAIT, I_READDATA, I_BUSYWAIT,
    output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );

  modport master (
    output D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA, I_READ, I_ADDRESS,
    output MEM_READDATA, MEM_BUSYWAIT,
    input  D_READDATA, D_BUSYWAIT, I_READDATA, I_BUSYWAIT,
    input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );

endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-request round-robin grant: a lone request wins, a tie goes to the port
// that did not win last time.
module mem_arbiter_rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic req_d,
  input  logic req_i,
  input  logic lg,
  output logic gnt_valid,
  output logic gnt_owner
);

  always_comb begin
    gnt_valid = req_d | req_i;
    gnt_owner = OWN_D;
    if (req_d && req_i) begin
      gnt_owner = ~lg;
    end else if (req_i) begin
      gnt_owner = OWN_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the data and instruction caches: round-robin
// grant, one transaction at a time, sticky latency watchdog.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic          CLK,
  input  logic          RESET,
  mem_arbiter_if.slave  bus,
  output logic          TIMEOUT_ERR
);

  localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  state_t            state;
  state_t            state_nxt;
  logic              owner;
  logic              lg;
  logic [CNT_W-1:0]  cnt;
  logic              timeout_err;
  logic              req_d;
  logic              req_i;
  logic              gnt_valid;
  logic              gnt_owner;
  logic              take_grant;
  logic              txn_done;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] d_readdata;
  logic [DATA_W-1:0] i_readdata;

  assign req_d = bus.D_READ | bus.D_WRITE;
  assign req_i = bus.I_READ;

  mem_arbiter_rr_arbiter2 u_rr (
    .req_d     (req_d),
    .req_i     (req_i),
    .lg        (lg),
    .gnt_valid (gnt_valid),
    .gnt_owner (gnt_owner)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    take_grant = 1'b0;
    txn_done   = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_valid) begin
          state_nxt  = ISSUE;
          take_grant = 1'b1;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (!bus.MEM_BUSYWAIT) begin
          state_nxt = DONE;
          txn_done  = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control: owner/last-grant, memory strobes and the saturating watchdog.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      owner       <= OWN_D;
      lg          <= OWN_I;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (take_grant) begin
        owner     <= gnt_owner;
        lg        <= gnt_owner;
        mem_read  <= (gnt_owner == OWN_I) | bus.D_READ;
        mem_write <= (gnt_owner == OWN_D) & bus.D_WRITE;
      end
      if (txn_done) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
        cnt       <= '0;
      end else if (state == WAIT && cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
        if (cnt == CNT_MAX - 1'b1) begin
          timeout_err <= 1'b1;
        end
      end
    end
  end

  // Datapath: request latch at grant, read return only to a still-waiting owner.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mem_address   <= '0;
      mem_writedata <= '0;
      d_readdata    <= '0;
      i_readdata    <= '0;
    end else begin
      if (take_grant) begin
        mem_address <= (gnt_owner == OWN_I) ? bus.I_ADDRESS : bus.D_ADDRESS;
        if (gnt_owner == OWN_D) begin
          mem_writedata <= bus.D_WRITEDATA;
        end
      end
      if (txn_done && mem_read && owner == OWN_D && bus.D_READ) begin
        d_readdata <= bus.MEM_READDATA;
      end
      if (txn_done && mem_read && owner == OWN_I && bus.I_READ) begin
        i_readdata <= bus.MEM_READDATA;
      end
    end
  end

  assign bus.D_BUSYWAIT    = req_d & ~(state == DONE && owner == OWN_D);
  assign bus.I_BUSYWAIT    = req_i & ~(state == DONE && owner == OWN_I);
  assign bus.MEM_READ      = mem_read;
  assign bus.MEM_WRITE     = mem_write;
  assign bus.MEM_ADDRESS   = mem_address;
  assign bus.MEM_WRITEDATA = mem_writedata;
  assign bus.D_READDATA    = d_readdata;
  assign bus.I_READDATA    = i_readdata;
  assign TIMEOUT_ERR       = timeout_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter with a behavioural memory and
// requester/arbitration reference model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int TO     = 64;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  logic TIMEOUT_ERR;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .bus         (bus.slave),
    .TIMEOUT_ERR (TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  int          n_cmp;
  int          n_bad;
  int          cyc;
  logic [31:0] mem_arr [64];
  logic [31:0] ref_mem [64];
  int          mem_lat;
  int          m_rem;
  int          m_lat_used;
  bit          m_act;
  logic [5:0]  m_addr;
  bit          m_we;
  logic        last_own;
  logic        serving;
  bit          rel_pend;
  int          g_cyc;
  int          rel_cyc;
  int          last_gap;
  bit          watch_to;
  logic        grant_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample pre-edge, then memory model, then requester releases.
  task automatic tick();
    logic d_bw, i_bw, d_req, i_req;
    #1;
    d_bw  = bus.D_BUSYWAIT;
    i_bw  = bus.I_BUSYWAIT;
    d_req = bus.D_READ | bus.D_WRITE;
    i_req = bus.I_READ;
    if (!d_req) chk("d_busywait_idle", d_bw, 0);
    if (!i_req) chk("i_busywait_idle", i_bw, 0);
    @(posedge CLK);
    #1;
    cyc++;
    if (!m_act && (bus.MEM_READ || bus.MEM_WRITE)) begin
      logic exp_own;
      chk("grant_had_request", d_req | i_req, 1);
      exp_own = (d_req && i_req) ? ~last_own : i_req;
      chk("grant_addr", bus.MEM_ADDRESS, exp_own ? bus.I_ADDRESS : bus.D_ADDRESS);
      chk("grant_write", bus.MEM_WRITE, !exp_own && bus.D_WRITE);
      chk("grant_read", bus.MEM_READ, exp_own || bus.D_READ);
      if (bus.MEM_WRITE) begin
        if (!exp_own) chk("grant_wdata", bus.MEM_WRITEDATA, bus.D_WRITEDATA);
        mem_arr[bus.MEM_ADDRESS] = bus.MEM_WRITEDATA;
      end
      last_own   = exp_own;
      serving    = exp_own;
      rel_pend   = 1'b1;
      last_gap   = cyc - rel_cyc;
      g_cyc      = cyc;
      m_act      = 1'b1;
      m_addr     = bus.MEM_ADDRESS;
      m_we       = bus.MEM_WRITE;
      m_rem      = mem_lat;
      m_lat_used = mem_lat;
      bus.MEM_BUSYWAIT = 1'b1;
    end else if (m_act && bus.MEM_BUSYWAIT) begin
      chk("strobe_held", {bus.MEM_READ, bus.MEM_WRITE}, m_we ? 2'b01 : 2'b10);
      chk("addr_held", bus.MEM_ADDRESS, m_addr);
      m_rem--;
      if (m_rem == 0) begin
        bus.MEM_BUSYWAIT = 1'b0;
        bus.MEM_READDATA = mem_arr[m_addr];
      end
    end else if (m_act && !bus.MEM_READ && !bus.MEM_WRITE) begin
      m_act = 1'b0;
    end
    if (watch_to) begin
      if (cyc == g_cyc + TO)     chk("timeout_not_yet", TIMEOUT_ERR, 0);
      if (cyc == g_cyc + TO + 1) chk("timeout_set", TIMEOUT_ERR, 1);
    end
    if (d_req && !d_bw) begin
      grant_q.push_back(OWN_D);
      chk("d_release_owner", {rel_pend, serving}, {1'b1, OWN_D});
      chk("d_latency", cyc - g_cyc, m_lat_used + 2);
      if (bus.D_READ) chk("d_readdata", bus.D_READDATA, ref_mem[bus.D_ADDRESS]);
      else ref_mem[bus.D_ADDRESS] = bus.D_WRITEDATA;
      rel_pend    = 1'b0;
      rel_cyc     = cyc;
      bus.D_READ  = 1'b0;
      bus.D_WRITE = 1'b0;
    end
    if (i_req && !i_bw) begin
      grant_q.push_back(OWN_I);
      chk("i_release_owner", {rel_pend, serving}, {1'b1, OWN_I});
      chk("i_latency", cyc - g_cyc, m_lat_used + 2);
      chk("i_readdata", bus.I_READDATA, ref_mem[bus.I_ADDRESS]);
      rel_pend   = 1'b0;
      rel_cyc    = cyc;
      bus.I_READ = 1'b0;
    end
  endtask

  task automatic do_reset(input int hold);
    RESET = 1'b0;
    #1;
    m_act = 1'b0;
    bus.MEM_BUSYWAIT = 1'b0;
    last_own = OWN_I;
    rel_pend = 1'b0;
    chk("rst_mem_read", bus.MEM_READ, 0);
    chk("rst_mem_write", bus.MEM_WRITE, 0);
    chk("rst_mem_address", bus.MEM_ADDRESS, 0);
    chk("rst_mem_writedata", bus.MEM_WRITEDATA, 0);
    chk("rst_d_readdata", bus.D_READDATA, 0);
    chk("rst_i_readdata", bus.I_READDATA, 0);
    chk("rst_timeout_err", TIMEOUT_ERR, 0);
    chk("rst_d_busywait", bus.D_BUSYWAIT, bus.D_READ | bus.D_WRITE);
    chk("rst_i_busywait", bus.I_BUSYWAIT, bus.I_READ);
    repeat (hold) tick();
    RESET = 1'b1;
  endtask

  task automatic drain(input int budget);
    int  k;
    logic busy;
    k = 0;
    while ((bus.D_READ || bus.D_WRITE || bus.I_READ || m_act) && k < budget) begin
      tick();
      k++;
    end
    busy = bus.D_READ | bus.D_WRITE | bus.I_READ | m_act;
    chk("drain_within_budget", busy, 0);
  endtask

  initial begin
    logic [31:0] prev;
    n_cmp = 0; n_bad = 0; cyc = 0;
    m_act = 1'b0; m_rem = 0; m_lat_used = 0; m_addr = '0; m_we = 1'b0;
    last_own = OWN_I; serving = OWN_D; rel_pend = 1'b0;
    g_cyc = -1000; rel_cyc = -1000; last_gap = 0; watch_to = 1'b0;
    bus.D_READ = 0; bus.D_WRITE = 0; bus.D_ADDRESS = '0; bus.D_WRITEDATA = '0;
    bus.I_READ = 0; bus.I_ADDRESS = '0;
    bus.MEM_READDATA = '0; bus.MEM_BUSYWAIT = 1'b0;
    for (int i = 0; i < 64; i++) begin
      mem_arr[i] = $urandom;
      ref_mem[i] = mem_arr[i];
    end
    #2;

    // D read held through reset, 5-cycle memory
    mem_lat = 5;
    mem_arr[5] = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;
    bus.D_READ = 1'b1; bus.D_ADDRESS = 6'h05;
    do_reset(3);
    drain(40);
    chk("t1_d_readdata", bus.D_READDATA, 32'hDEADBEEF);

    // D write, then read it back through the I port
    mem_lat = 4;
    bus.D_WRITE = 1'b1; bus.D_ADDRESS = 6'h2A; bus.D_WRITEDATA = 32'h11223344;
    drain(40);
    chk("t2_mem_written", mem_arr[6'h2A], 32'h11223344);
    bus.I_READ = 1'b1; bus.I_ADDRESS = 6'h2A;
    drain(40);
    chk("t2_i_readback", bus.I_READDATA, 32'h11223344);

    // simultaneous requests after reset, then both kept asserted
    do_reset(2);
    grant_q.delete();
    mem_lat = 2;
    bus.D_READ = 1'b1; bus.D_ADDRESS = 6'h10;
    bus.I_READ = 1'b1; bus.I_ADDRESS = 6'h20;
    for (int k = 0; k < 200 && grant_q.size() < 5; k++) begin
      tick();
      if (!bus.D_READ) bus.D_READ = 1'b1;
      if (!bus.I_READ) bus.I_READ = 1'b1;
    end
    drain(40);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t3_grant%0d", k), (k < grant_q.size()) ? grant_q[k] : 1'bx, k % 2);
    end

    // D write arrives while a slow I read is in flight
    grant_q.delete();
    mem_lat = 10;
    bus.I_READ = 1'b1; bus.I_ADDRESS = 6'h21;
    repeat (4) tick();
    bus.D_WRITE = 1'b1; bus.D_ADDRESS = 6'h22; bus.D_WRITEDATA = $urandom;
    drain(60);
    chk("t4_order", (grant_q.size() == 2) ? {grant_q[0], grant_q[1]} : 2'bxx, {OWN_I, OWN_D});
    chk("t4_idle_gap", last_gap, 1);

    // I withdraws its read mid-transaction
    prev = bus.I_READDATA;
    mem_arr[6'h33] = ~prev; ref_mem[6'h33] = ~prev;
    mem_lat = 6;
    bus.I_READ = 1'b1; bus.I_ADDRESS = 6'h33;
    repeat (3) tick();
    bus.I_READ = 1'b0;
    repeat (12) tick();
    chk("t5_i_readdata_kept", bus.I_READDATA, prev);
    bus.D_READ = 1'b1; bus.D_ADDRESS = 6'h33;
    drain(40);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      mem_lat = $urandom_range(1, 6);
      if (!(bus.D_READ || bus.D_WRITE) && $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 0) bus.D_READ = 1'b1;
        else bus.D_WRITE = 1'b1;
        bus.D_ADDRESS   = 6'($urandom);
        bus.D_WRITEDATA = $urandom;
      end
      if (!bus.I_READ && $urandom_range(0, 2) == 0) begin
        bus.I_READ    = 1'b1;
        bus.I_ADDRESS = 6'($urandom);
      end
      tick();
    end
    drain(100);
    chk("rand_no_timeout", TIMEOUT_ERR, 0);

    // 70-cycle memory stall
    watch_to = 1'b1; g_cyc = -1000;
    mem_lat = 70;
    bus.I_READ = 1'b1; bus.I_ADDRESS = 6'h07;
    drain(120);
    watch_to = 1'b0;
    chk("to_sticky_after_done", TIMEOUT_ERR, 1);
    mem_arr[6'h08] = 32'hCAFE0008; ref_mem[6'h08] = 32'hCAFE0008;
    mem_lat = 3;
    bus.D_READ = 1'b1; bus.D_ADDRESS = 6'h08;
    drain(40);
    chk("to_sticky_next_txn", TIMEOUT_ERR, 1);

    // reset during WAIT of a D read, then re-request
    mem_lat = 8;
    bus.D_READ = 1'b1; bus.D_ADDRESS = 6'h11;
    repeat (4) tick();
    chk("t8_in_wait_read", bus.MEM_READ, 1);
    do_reset(2);
    drain(40);
    chk("t8_d_readdata", bus.D_READDATA, ref_mem[6'h11]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
